// File: rtl/dram_latency_model.sv
// dram_latency_model: burst-addressed DRAM endpoint with a programmable fixed
// response latency. Commands are serviced at accept time (writes update the
// backing store, reads snapshot it) and responses leave in acceptance order
// once LATENCY cycles have elapsed since their stamp.
//
// Handshakes: both channels use strict valid/ready. A beat transfers on a
// rising edge where valid & ready. A source never withdraws valid or changes
// bits while it waits for ready. io_dram_resp_valid and io_dram_resp_bits_*
// are functions of registered state only, so they hold steady under
// back-pressure.
module dram_latency_model #(
    parameter int W_WORD    = 32,
    parameter int N_WORDS   = 16,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 8,
    parameter int QDEPTH    = 8,
    parameter int WR_RESP   = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_dram_cmd_valid,
    output logic                        io_dram_cmd_ready,
    input  logic [ADDR_W-1:0]           io_dram_cmd_bits_addr,
    input  logic                        io_dram_cmd_bits_isWr,
    input  logic [TAG_W-1:0]            io_dram_cmd_bits_tag,
    input  logic [TAG_W-1:0]            io_dram_cmd_bits_streamId,
    input  logic [N_WORDS*W_WORD-1:0]   io_dram_cmd_bits_wdata,
    output logic                        io_dram_resp_valid,
    input  logic                        io_dram_resp_ready,
    output logic [N_WORDS*W_WORD-1:0]   io_dram_resp_bits_rdata,
    output logic [TAG_W-1:0]            io_dram_resp_bits_tag,
    output logic [TAG_W-1:0]            io_dram_resp_bits_streamId,
    output logic                        io_dram_resp_bits_isWr,
    output logic [$clog2(QDEPTH):0]     io_outstanding
);

    localparam int DW     = N_WORDS * W_WORD;
    localparam int OFF    = $clog2(DW / 8);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int QA_W   = $clog2(QDEPTH);
    localparam int CNT_W  = QA_W + 1;
    localparam logic [15:0]      LAT16  = 16'(LATENCY);
    localparam logic [CNT_W-1:0] QFULL  = CNT_W'(QDEPTH);
    localparam logic             POSTED = (WR_RESP == 0);

    // Backing store, one entry per burst; never cleared by reset.
    logic [DW-1:0]    mem [MEM_DEPTH];

    // Response queue storage, indexed by the ring pointers below.
    logic [TAG_W-1:0] q_tag   [QDEPTH];
    logic [TAG_W-1:0] q_sid   [QDEPTH];
    logic             q_iswr  [QDEPTH];
    logic [DW-1:0]    q_rdata [QDEPTH];
    logic [15:0]      q_stamp [QDEPTH];

    logic [QA_W-1:0]  wr_ptr;
    logic [QA_W-1:0]  rd_ptr;
    logic [CNT_W-1:0] count;
    logic [15:0]      now;

    logic [IDX_W-1:0] idx;
    logic             not_full;
    logic             accept;
    logic             push;
    logic             pop;
    logic [15:0]      age;
    logic             head_eligible;
    logic [DW-1:0]    snap;
    logic             unused_addr;

    // Only the burst-index field of the address selects storage; offset bits
    // within a burst and bits above the store size are deliberately dropped.
    assign idx         = io_dram_cmd_bits_addr[OFF +: IDX_W];
    assign unused_addr = ^io_dram_cmd_bits_addr;

    assign not_full = (count < QFULL);

    // Posted writes never occupy a queue slot, so they can bypass a full queue.
    assign io_dram_cmd_ready = ~reset & (not_full | (POSTED & io_dram_cmd_bits_isWr));
    assign accept            = io_dram_cmd_valid & io_dram_cmd_ready;
    assign push              = accept & (~io_dram_cmd_bits_isWr | ~POSTED);

    // Age is taken modulo 2^16 so the free-running counter may wrap freely.
    assign age           = now - q_stamp[rd_ptr];
    assign head_eligible = (count != '0) & (age >= LAT16);

    assign io_dram_resp_valid = ~reset & head_eligible;
    assign pop                = io_dram_resp_valid & io_dram_resp_ready;

    assign snap = io_dram_cmd_bits_isWr ? '0 : mem[idx];

    assign io_dram_resp_bits_rdata    = q_rdata[rd_ptr];
    assign io_dram_resp_bits_tag      = q_tag[rd_ptr];
    assign io_dram_resp_bits_streamId = q_sid[rd_ptr];
    assign io_dram_resp_bits_isWr     = q_iswr[rd_ptr];
    assign io_outstanding             = count;

    // Accepted writes land in the store on the accept edge.
    always_ff @(posedge clock) begin
        if (accept && io_dram_cmd_bits_isWr) begin
            mem[idx] <= io_dram_cmd_bits_wdata;
        end
    end

    // Queue payload: the read snapshot is captured now, so later writes to
    // the same burst cannot leak into an already-accepted read.
    always_ff @(posedge clock) begin
        if (push) begin
            q_tag[wr_ptr]   <= io_dram_cmd_bits_tag;
            q_sid[wr_ptr]   <= io_dram_cmd_bits_streamId;
            q_iswr[wr_ptr]  <= io_dram_cmd_bits_isWr;
            q_rdata[wr_ptr] <= snap;
            q_stamp[wr_ptr] <= now;
        end
    end

    // Queue pointers, occupancy and the free-running cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            now    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            now <= now + 16'd1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/dram_latency_model.md
Name: dram_latency_model

Overview:
- Parametrised, synthesizable DRAM endpoint model.
- Replaces the C-side DRAM service loop for Top-level simulation and emulation builds.
- Accepts burst commands on the io_dram_cmd ready/valid channel, services them from an internal burst-addressed memory, and returns responses on io_dram_resp after a programmable fixed latency.
- Responses return in acceptance order, with a bounded number of commands outstanding.

Parameters:
- W_WORD, 32, bits per data word.
- N_WORDS, 16, words per burst (burst bytes = N_WORDS*W_WORD/8, power of two).
- ADDR_W, 32, command address width.
- TAG_W, 32, tag and streamId width.
- MEM_DEPTH, 1024, bursts of backing store (power of two).
- LATENCY, 8, minimum cycles from accept to resp_valid (>=1).
- QDEPTH, 8, max outstanding responses (power of two, >=2).
- WR_RESP, 1, 1 = writes return a response; 0 = writes are posted, with no response.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- io_dram_cmd_valid  in  1  command valid
- io_dram_cmd_ready  out  1  command accepted when valid&ready
- io_dram_cmd_bits_addr  in  ADDR_W  byte address
- io_dram_cmd_bits_isWr  in  1  1 = write
- io_dram_cmd_bits_tag  in  TAG_W  request tag
- io_dram_cmd_bits_streamId  in  TAG_W  stream id
- io_dram_cmd_bits_wdata  in  N_WORDS*W_WORD  write burst; word i at [i*W_WORD +: W_WORD]
- io_dram_resp_valid  out  1  response valid
- io_dram_resp_ready  in  1  response consumed when valid&ready
- io_dram_resp_bits_rdata  out  N_WORDS*W_WORD  read burst, same packing as wdata
- io_dram_resp_bits_tag  out  TAG_W  echoed tag
- io_dram_resp_bits_streamId  out  TAG_W  echoed streamId
- io_dram_resp_bits_isWr  out  1  1 = write acknowledge
- io_outstanding  out  clog2(QDEPTH)+1  queued response count

Behaviour:
- Reset:
  - While reset=1 at a rising edge: queue cleared, cycle counter = 0, io_dram_resp_valid = 0, io_outstanding = 0, io_dram_cmd_ready = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all queued responses; any in-flight write already applied stays applied.
  - io_dram_cmd_ready = 1 from the first cycle after reset deasserts, if the queue is not full.
- Address mapping:
  - burst index = addr[OFF +: clog2(MEM_DEPTH)], where OFF = clog2(N_WORDS*W_WORD/8).
  - Low OFF bits are ignored.
  - Upper bits are ignored, so out-of-range addresses wrap.
- Ready:
  - io_dram_cmd_ready = ~reset & (count < QDEPTH). There is no same-cycle bypass from a response pop.
  - With WR_RESP=0, a write is accepted even when the queue is full: ready = ~reset & (~isWr ? count<QDEPTH : 1).
- Accept, on the cycle valid&ready:
  - Write: memory[idx] <= wdata on that edge.
  - Read: memory[idx] is snapshotted into the queue entry at accept. Later writes do not affect an already-accepted read (program-order semantics).
  - Enqueued entry = {tag, streamId, isWr, rdata snapshot (zero for writes), stamp = cycle counter}.
  - Writes are not enqueued when WR_RESP=0.
- Timing:
  - The cycle counter is free-running, 16 bits, and wraps.
  - The head entry is eligible when (now - stamp) mod 2^16 >= LATENCY.
  - LATENCY < 2^15 is required.
  - A command accepted at edge t makes resp_valid high in the cycle following edge t+LATENCY-1. LATENCY=1 therefore means resp_valid in the cycle right after acceptance.
- Response:
  - io_dram_resp_valid = head eligible.
  - bits = head fields, registered and stable while valid & ~ready.
  - The head is popped on valid&ready; the next entry may be valid in the following cycle if it is eligible.
  - Back-pressure delays only; order is strict FIFO.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged.
  - When full, a pop frees a slot that ready reflects in the next cycle.
  - A read and a write in the same cycle are impossible, since there is one command per cycle.
- io_outstanding = current queue count, registered.

Test Plan:
- Single read after reset, memory[3] preloaded with word i = 0x100+i, LATENCY=8:
  - Stimulus: read addr=0xC0, tag=5 at edge 10, resp_ready=1.
  - Required: resp_valid first high after edge 17; rdata words = 0x100..0x10F; tag=5; isWr=0; one cycle only.
- Write then read, same address:
  - Stimulus: write addr=0x40 with all words 0xDEADBEEF, tag=1; next cycle read addr=0x40, tag=2.
  - Required: responses in order tag1 (isWr=1, rdata 0), then tag2 with rdata all 0xDEADBEEF.
- Read-before-write snapshot:
  - Stimulus: read 0x80 (memory holds 0), then write 0x80 = 0x55.
  - Required: read response rdata = 0.
- Full queue, QDEPTH=8:
  - Stimulus: 8 reads with resp_ready=0.
  - Required: io_outstanding=8 and cmd_ready=0; a 9th valid stalls.
  - Then: raise resp_ready for one cycle; 1 pop, cmd_ready=1 the next cycle, and the 9th read is accepted.
- Back-pressure stability:
  - Stimulus: hold resp_ready=0 for 20 cycles after valid.
  - Required: tag/rdata unchanged every cycle; release yields the response once, no duplicate.
- Reset mid-flight plus posted writes:
  - Stimulus: 3 reads outstanding, then reset for 1 cycle.
  - Required: io_outstanding=0, resp_valid=0, and no stale responses.
  - Also, with WR_RESP=0 and a full queue: a write is accepted, memory is updated, and no response appears.
- Counter wrap:
  - Stimulus: issue a read when the counter = 0xFFFC, LATENCY=8.
  - Required: response appears exactly 8 cycles later.
